mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath, sitting directly downstream of the instruction-fetch unit. It consumes the fetched instruction word and the ALU `zero` flag, sequences each instruction through IF/DCD/EXE/MEM/WB states, and drives the fetch unit's PC-update controls (`pc_wr`, `nPC_sel`, `jumpCtr`) together with the datapath enables. Each instruction takes 2–5 cycles, and the PC advances exactly once per instruction.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mc_ctrl_dec.sv | 32 +++
 rtl/mc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, functs, state
// encoding, datapath select encodings and the decoded instruction class.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ST_IF    = 3'd0;
    localparam logic [2:0] ST_DCD   = 3'd1;
    localparam logic [2:0] ST_EXE   = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_WB    = 3'd4;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;

    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;

    localparam logic [1:0] RD_RT    = 2'd0;
    localparam logic [1:0] RD_RD    = 2'd1;
    localparam logic [1:0] RD_RA    = 2'd2;

    localparam logic [1:0] M2R_ALU  = 2'd0;
    localparam logic [1:0] M2R_MEM  = 2'd1;
    localparam logic [1:0] M2R_PC4  = 2'd2;

    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic jal;
    } ins_cls_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src;
        logic [1:0] ext_op;
    } alu_ctl_t;

    // ALU/extender settings used from EXE through WB; jumps leave everything at 0.
    function automatic alu_ctl_t alu_ctl(input ins_cls_t c);
        alu_ctl_t r;
        r = '0;
        if (c.subu || c.beq) r.alu_op = ALU_SUB;
        if (c.ori)           r.alu_op = ALU_OR;
        if (c.ori || c.lui || c.lw || c.sw) r.alu_src = 1'b1;
        if (c.lw || c.sw)    r.ext_op = EXT_SIGN;
        if (c.lui)           r.ext_op = EXT_LUI;
        return r;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decoder: opcode/funct to a one-hot class plus an
// illegal flag for anything outside the supported subset.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ins_cls_t   cls,
    output logic       illegal
);

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                cls.addu = (funct == FN_ADDU);
                cls.subu = (funct == FN_SUBU);
                cls.jr   = (funct == FN_JR);
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls = '0;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: IF/DCD/EXE/MEM/WB FSM, IR latch and optional
// performance counters (enabled with MC_CTRL_PERF_EN).
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned IR_LATCH = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic        pc_wr,
    output logic        nPC_sel,
    output logic        jumpCtr,
    output logic        ir_wr,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic        alu_src,
    output logic [1:0]  ext_op,
    output logic [2:0]  alu_op,
    output logic        mem_wr,
    output logic [1:0]  mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] ret_cnt
`endif
);

    logic [2:0]  state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] dec_ir;
    ins_cls_t    cls;
    logic        dec_illegal;
    alu_ctl_t    ctl;

    generate
        if (IR_LATCH != 0) begin : g_ir
            assign dec_ir = ir_q;
        end else begin : g_noir
            assign dec_ir = ins;
        end
    endgenerate

    mc_ctrl_dec u_dec (
        .op      (dec_ir[31:26]),
        .funct   (dec_ir[5:0]),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // The fetch unit consumes zero itself; the controller only passes nPC_sel.
    logic unused_bits;
    assign unused_bits = ^{zero, dec_ir[25:6]};

    assign ctl   = alu_ctl(cls);
    assign state = state_q;
    assign ir_d  = (state_q == ST_IF) ? ins : ir_q;

    always_comb begin
        state_d    = ST_IF;
        pc_wr      = 1'b0;
        nPC_sel    = 1'b0;
        jumpCtr    = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = RD_RT;
        alu_src    = 1'b0;
        ext_op     = EXT_ZERO;
        alu_op     = ALU_ADD;
        mem_wr     = 1'b0;
        mem_to_reg = M2R_ALU;
        illegal    = 1'b0;
        case (state_q)
            ST_IF: begin
                ir_wr   = 1'b1;
                state_d = ST_DCD;
            end
            ST_DCD: begin
                if (dec_illegal) begin
                    illegal = 1'b1;
                    pc_wr   = 1'b1;
                end else if (cls.j || cls.jal || cls.jr) begin
                    pc_wr   = 1'b1;
                    jumpCtr = 1'b1;
                    if (cls.jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC4;
                    end
                end else begin
                    state_d = ST_EXE;
                end
            end
            ST_EXE: begin
                {alu_op, alu_src, ext_op} = ctl;
                if (cls.beq) begin
                    nPC_sel = 1'b1;
                    pc_wr   = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                {alu_op, alu_src, ext_op} = ctl;
                if (cls.sw) begin
                    mem_wr = 1'b1;
                    pc_wr  = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                {alu_op, alu_src, ext_op} = ctl;
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                mem_to_reg = cls.lw ? M2R_MEM : M2R_ALU;
                reg_dst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
            end
            default: state_d = ST_IF;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IF;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q + 32'd1;
        ret_cnt_d = ret_cnt_q + {31'd0, pc_wr && !illegal};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            cyc_cnt_q <= cyc_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction expected output sequences are
// derived from instruction classes and compared every cycle by a monitor.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_wr;
        logic       npc;
        logic       jmp;
        logic       ir_wr;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [2:0] alu_op;
        logic       mem_wr;
        logic [1:0] m2r;
        logic       illegal;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ins   = '0;
    logic        zero  = 1'b0;
    logic        pc_wr, nPC_sel, jumpCtr, ir_wr, reg_wr, alu_src, mem_wr, illegal;
    logic [1:0]  reg_dst, ext_op, mem_to_reg;
    logic [2:0]  alu_op, state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    mc_ctrl dut (
        .clock(clock), .reset(reset), .ins(ins), .zero(zero),
        .pc_wr(pc_wr), .nPC_sel(nPC_sel), .jumpCtr(jumpCtr), .ir_wr(ir_wr),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op),
        .alu_op(alu_op), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
        , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    rec_t        sb[$];
    logic [31:0] m_cyc = '0;
    logic [31:0] m_ret = '0;
    logic        ret_pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Instruction kinds: 0 addu 1 subu 2 jr 3 ori 4 lw 5 sw 6 beq 7 lui 8 j 9 jal 10 illegal
    function automatic int classify(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'd0) begin
            if (fn == 6'b100001) return 0;
            if (fn == 6'b100011) return 1;
            if (fn == 6'b001000) return 2;
            return 10;
        end
        case (op)
            6'b001101: return 3;
            6'b100011: return 4;
            6'b101011: return 5;
            6'b000100: return 6;
            6'b001111: return 7;
            6'b000010: return 8;
            6'b000011: return 9;
            default:   return 10;
        endcase
    endfunction

    task automatic model_push(input logic [31:0] w, input int cut, output int n);
        int         k;
        rec_t       r;
        logic [2:0] path[$];
        k = classify(w);
        if (k == 2 || k >= 8)       path = '{3'd0, 3'd1};
        else if (k == 6)            path = '{3'd0, 3'd1, 3'd2};
        else if (k == 5)            path = '{3'd0, 3'd1, 3'd2, 3'd3};
        else if (k == 4)            path = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        else                        path = '{3'd0, 3'd1, 3'd2, 3'd4};
        n = path.size();
        if (cut > 0 && cut < n) n = cut;
        for (int i = 0; i < n; i++) begin
            r = '0;
            r.state = path[i];
            r.pc_wr = (i == path.size() - 1);
            if (path[i] == 3'd0) r.ir_wr = 1'b1;
            if (path[i] >= 3'd2) begin
                case (k)
                    1: r.alu_op = 3'd1;
                    3: begin r.alu_op = 3'd2; r.alu_src = 1'b1; end
                    4, 5: begin r.alu_src = 1'b1; r.ext_op = 2'd1; end
                    6: r.alu_op = 3'd1;
                    7: begin r.alu_src = 1'b1; r.ext_op = 2'd2; end
                    default: ;
                endcase
            end
            if (path[i] == 3'd1) begin
                if (k == 2 || k == 8 || k == 9) r.jmp = 1'b1;
                if (k == 9) begin r.reg_wr = 1'b1; r.reg_dst = 2'd2; r.m2r = 2'd2; end
                if (k == 10) r.illegal = 1'b1;
            end
            if (path[i] == 3'd2 && k == 6) r.npc = 1'b1;
            if (path[i] == 3'd3 && k == 5) r.mem_wr = 1'b1;
            if (path[i] == 3'd4) begin
                r.reg_wr  = 1'b1;
                r.reg_dst = (k <= 1) ? 2'd1 : 2'd0;
                r.m2r     = (k == 4) ? 2'd1 : 2'd0;
            end
            sb.push_back(r);
        end
    endtask

    // Runs one instruction; ins is scrambled after IR capture, zero forced in EXE.
    task automatic run_ins(input logic [31:0] w, input logic zv, input int cut);
        int n;
        model_push(w, cut, n);
        ins  = w;
        zero = 1'($urandom);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) ins = $urandom;
            zero = (c == 1) ? zv : 1'($urandom);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        m_cyc = '0;
        m_ret = '0;
        repeat (cycles) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    always @(posedge clock) begin
        if (!reset) begin
            m_cyc = m_cyc + 32'd1;
            if (ret_pend) m_ret = m_ret + 32'd1;
        end
        ret_pend = 1'b0;
    end

    always @(negedge clock) begin
        rec_t act, exp;
        act = '{state: state, pc_wr: pc_wr, npc: nPC_sel, jmp: jumpCtr, ir_wr: ir_wr,
                reg_wr: reg_wr, reg_dst: reg_dst, alu_src: alu_src, ext_op: ext_op,
                alu_op: alu_op, mem_wr: mem_wr, m2r: mem_to_reg, illegal: illegal};
        if (reset) begin
            exp = '0;
            exp.ir_wr = 1'b1;
            chk("reset_outputs", 64'(act), 64'(exp));
        end else if (sb.size() == 0) begin
            chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            chk("cycle_outputs", 64'(act), 64'(exp));
            ret_pend = exp.pc_wr && !exp.illegal;
        end
`ifdef MC_CTRL_PERF_EN
        chk("cyc_cnt", 64'(cyc_cnt), 64'(m_cyc));
        chk("ret_cnt", 64'(ret_cnt), 64'(m_ret));
`endif
    end

    function automatic logic [31:0] rand_ins();
        logic [31:0] w;
        logic [5:0]  ops[8];
        logic [5:0]  fns[3];
        ops = '{6'b001101, 6'b100011, 6'b101011, 6'b000100,
                6'b001111, 6'b000010, 6'b000011, 6'b000000};
        fns = '{6'b100001, 6'b100011, 6'b001000};
        w = $urandom;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: w[31:26] = ops[$urandom_range(0, 7)];
            6, 7: begin w[31:26] = 6'd0; w[5:0] = fns[$urandom_range(0, 2)]; end
            8: w[31:26] = 6'd0;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] dir[10];
        dir = '{32'h0000_0000, 32'h0022_1823, 32'h3421_FFFF, 32'h3C01_1234,
                32'h0800_0010, 32'h03E0_0008, 32'h0000_002A, 32'h1400_0001,
                32'h8C08_0004, 32'h0022_1821};
        reset = 1'b1;
        do_reset(3);
        run_ins(32'h0022_1821, 1'b0, 0);
        run_ins(32'h8C08_0004, 1'b0, 0);
        run_ins(32'hAC08_0004, 1'b0, 0);
        run_ins(32'h1000_0001, 1'b1, 0);
        run_ins(32'h1000_0001, 1'b0, 0);
        run_ins(32'h0C00_0300, 1'b0, 0);
        run_ins(32'hFC00_0000, 1'b0, 0);
        foreach (dir[i]) run_ins(dir[i], 1'($urandom), 0);
        // sw abandoned in MEM by reset, then re-executed from IF
        run_ins(32'hAC08_0004, 1'b0, 3);
        do_reset(2);
        run_ins(32'hAC08_0004, 1'b0, 0);
        for (int i = 0; i < 300; i++) begin
            run_ins(rand_ins(), 1'($urandom), 0);
            if (i == 150) begin
                run_ins(32'h8C08_0004, 1'b0, $urandom_range(1, 4));
                do_reset($urandom_range(1, 3));
            end
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
